load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the ALU in the RV32I core, between the core and a handshaked data bus.
- Takes the ALU-computed effective address, funct3 and rs2 store data, and drives a req/ack memory bus with byte enables.
- Returns aligned, sign/zero-extended load data toward the writeback mux.
- Stalls the core, by holding the PC and suppressing register write, until the access completes.

Parameters:
TIMEOUT, 16, max BUSY cycles without bus_ack/bus_err before the access is aborted with access_fault.

Ports:
clk  in  1  core clock, all state rising-edge
rst_n  in  1  reset, asynchronous, active-low
mem_read  in  1  load request from main_control
mem_write  in  1  store request from main_control
funct3  in  3  access size/sign (inst[14:12])
addr  in  32  effective address (ALU output)
store_data  in  32  rs2 value
load_data  out  32  formatted load result, valid in DONE
stall  out  1  core must hold PC and suppress reg write
misaligned  out  1  combinational, misaligned request this cycle
access_fault  out  1  registered, bus error / timeout / illegal funct3
bus_req  out  1  bus request, held until ack/err
bus_we  out  1  1 = write
bus_addr  out  32  word address, {addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables
bus_ack  in  1  access complete, rdata valid on reads
bus_rdata  in  32  read word
bus_err  in  1  bus error, terminates access

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_be, load_data, access_fault, timeout counter all 0.
  - Asserting reset mid-access drops bus_req immediately; the in-flight access is abandoned.
- Request decode in IDLE:
  - req = mem_read|mem_write. If both are set, treat as a write.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3: 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Alignment:
  - Halfword is misaligned if addr[0]=1; word is misaligned if addr[1:0]!=0.
  - misaligned = IDLE & req & legal & misaligned_addr (combinational).
  - A misaligned request gets no bus access and no stall; next-cycle load_data=0.
- Illegal funct3 with req: no bus access, no stall; access_fault pulses for 1 cycle on the next cycle.
- Byte enables:
  - Byte: be = 4'b0001<<addr[1:0].
  - Half: be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: be = 4'b1111.
  - Same pattern on reads.
- Write data:
  - SB: {4{sd[7:0]}}
  - SH: {2{sd[15:0]}}
  - SW: sd
- FSM IDLE -> BUSY -> DONE -> IDLE:
  - IDLE:
    - stall = req & legal & aligned (combinational, same cycle).
    - On that condition, at the clock edge: latch we, funct3, addr[1:0], bus_addr, bus_wdata, bus_be; set bus_req=1; clear the counter; go BUSY.
    - Latency: bus_req is visible 1 cycle after the request.
  - BUSY:
    - stall=1; bus outputs are stable and must not change while bus_req=1; the counter increments each cycle.
    - bus_ack: bus_req<=0. On a read, load_data <= formatted bus_rdata; on a write, load_data is unchanged. Go DONE.
    - bus_err (priority over ack if both are set), or counter==TIMEOUT-1 without ack: bus_req<=0, access_fault<=1, load_data<=0, go DONE.
  - DONE:
    - stall=0 for exactly 1 cycle, so the core retires the instruction using load_data.
    - mem_read/mem_write are ignored, which prevents a re-issue of the same instruction.
    - access_fault clears at exit. Go IDLE.
- Load formatting: sel = latched addr[1:0].
  - LB: sign-extend byte[sel]. LBU: zero-extend byte[sel].
  - LH: sign-extend half[sel[1]]. LHU: zero-extend half[sel[1]].
  - LW: full word.
- Back-to-back accesses: minimum 3 cycles per access (IDLE accept, ≥1 BUSY, DONE). With ack in the first BUSY cycle, stall is high 2 cycles.
- A bus_ack arriving in IDLE or DONE is ignored.

Test Plan:
- LW, addr=0x100, rdata=0xDEADBEEF, ack 2 cycles after req -> bus_addr=0x100, be=1111, we=0, stall high 3 cycles, load_data=0xDEADBEEF in DONE.
- LB addr=0x203 and LBU addr=0x203, rdata=0x80FF1234 -> be=1000; LB load_data=0xFFFFFF80, LBU load_data=0x00000080.
- SH addr=0x42, store_data=0x0000ABCD, ack immediate -> bus_addr=0x40, be=1100, wdata=0xABCDABCD, we=1, stall high 2 cycles, load_data unchanged.
- LW addr=0x102 -> misaligned=1 same cycle, bus_req stays 0, stall=0. funct3=011 with mem_read -> access_fault pulse next cycle, no bus_req.
- LH addr=0x10, no ack, TIMEOUT=16 -> bus_req high 16 cycles then drops, access_fault=1 and load_data=0 in DONE. Repeat with bus_err at cycle 3 -> fault at cycle 3 even if ack is also set.
- Reset mid-BUSY: rst_n low asynchronously -> bus_req=0 immediately. After release: state IDLE, stall=0, a following ack is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes size/sign from funct3, drives a req/ack data bus
// with byte enables and returns formatted load data, stalling the core until done.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        access_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    lat_funct3;
  logic [1:0]    lat_sel;

  logic          req, legal, mis_addr, accept, abort, timeout_hit;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt, fmt_data;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  always_comb begin
    req      = mem_read | mem_write;
    legal    = 1'b0;
    mis_addr = 1'b0;
    be_nxt   = 4'b1111;
    wdata_nxt = store_data;
    // Both strobes set is a store, so load-only encodings become illegal then.
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~mem_write;
      default:                legal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{store_data[7:0]}};
      end
      2'b01: begin
        mis_addr  = addr[0];
        be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{store_data[15:0]}};
      end
      default: mis_addr = (addr[1:0] != 2'b00);
    endcase
    accept      = (state == IDLE) & req & legal & ~mis_addr;
    misaligned  = (state == IDLE) & req & legal & mis_addr;
    stall       = accept | (state == BUSY);
    timeout_hit = (cnt == CNT_LAST);
    abort       = bus_err | (~bus_ack & timeout_hit);
  end

  always_comb begin
    sel_byte = bus_rdata[7:0];
    case (lat_sel)
      2'd1:    sel_byte = bus_rdata[15:8];
      2'd2:    sel_byte = bus_rdata[23:16];
      2'd3:    sel_byte = bus_rdata[31:24];
      default: sel_byte = bus_rdata[7:0];
    endcase
    sel_half = lat_sel[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lat_funct3)
      3'b000:  fmt_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  fmt_data = {24'd0, sel_byte};
      3'b001:  fmt_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  fmt_data = {16'd0, sel_half};
      default: fmt_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (bus_err || bus_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_be       <= '0;
      load_data    <= '0;
      access_fault <= 1'b0;
      cnt          <= '0;
      lat_funct3   <= '0;
      lat_sel      <= '0;
    end else begin
      case (state)
        IDLE: begin
          access_fault <= req & ~legal;
          if (misaligned) load_data <= '0;
          if (accept) begin
            bus_req    <= 1'b1;
            bus_we     <= mem_write;
            bus_addr   <= {addr[31:2], 2'b00};
            bus_wdata  <= wdata_nxt;
            bus_be     <= be_nxt;
            lat_funct3 <= funct3;
            lat_sel    <= addr[1:0];
            cnt        <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (abort) begin
            bus_req      <= 1'b0;
            access_fault <= 1'b1;
            load_data    <= '0;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) load_data <= fmt_data;
          end
        end
        DONE:    access_fault <= 1'b0;
        default: access_fault <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed loads, stores, alignment,
// illegal funct3, timeout, bus error and mid-access reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall, misaligned, access_fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  int          stall_cycles;
  int          req_cycles;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data),
    .load_data(load_data), .stall(stall), .misaligned(misaligned),
    .access_fault(access_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, ack after ack_delay BUSY cycles without ack; ends in DONE.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdata, input int ack_delay);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    #1;
    stall_cycles = 0;
    if (stall) stall_cycles++;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    cap_addr = bus_addr; cap_be = bus_be; cap_we = bus_we; cap_wdata = bus_wdata;
    for (int i = 0; i < ack_delay; i++) begin
      if (stall) stall_cycles++;
      tick();
    end
    bus_ack = 1'b1; bus_rdata = rdata;
    #1;
    if (stall) stall_cycles++;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    addr = '0; store_data = '0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    #12;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_fault", {31'd0, access_fault}, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // LW with one wait cycle
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_be", {28'd0, cap_be}, 32'hF);
    check("lw_we", {31'd0, cap_we}, 32'd0);
    check("lw_stall_cycles", stall_cycles, 32'd3);
    check("lw_data", load_data, 32'hDEADBEEF);
    check("lw_done_stall", {31'd0, stall}, 32'd0);
    check("lw_done_req", {31'd0, bus_req}, 32'd0);
    tick();

    access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0);
    check("lb_be", {28'd0, cap_be}, 32'h8);
    check("lb_addr", cap_addr, 32'h200);
    check("lb_data", load_data, 32'hFFFFFF80);
    tick();
    access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 0);
    check("lbu_data", load_data, 32'h00000080);
    tick();
    access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF1234, 0);
    check("lh_be", {28'd0, cap_be}, 32'hC);
    check("lh_data", load_data, 32'hFFFF80FF);
    tick();
    access(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 32'h80FF1234, 0);
    check("lhu_be", {28'd0, cap_be}, 32'h3);
    check("lhu_data", load_data, 32'h00001234);
    tick();
    access(1'b1, 1'b0, 3'b000, 32'h201, 32'h0, 32'h80FF1234, 0);
    check("lb1_be", {28'd0, cap_be}, 32'h2);
    check("lb1_data", load_data, 32'h00000012);
    tick();

    // Stores leave load_data untouched
    access(1'b0, 1'b1, 3'b001, 32'h42, 32'h0000ABCD, 32'h11111111, 0);
    check("sh_addr", cap_addr, 32'h40);
    check("sh_be", {28'd0, cap_be}, 32'hC);
    check("sh_wdata", cap_wdata, 32'hABCDABCD);
    check("sh_we", {31'd0, cap_we}, 32'd1);
    check("sh_stall_cycles", stall_cycles, 32'd2);
    check("sh_load_data", load_data, 32'h00000012);
    tick();
    access(1'b0, 1'b1, 3'b000, 32'h1, 32'h12345678, 32'h0, 0);
    check("sb_be", {28'd0, cap_be}, 32'h2);
    check("sb_wdata", cap_wdata, 32'h78787878);
    tick();
    access(1'b0, 1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 32'h0, 0);
    check("sw_be", {28'd0, cap_be}, 32'hF);
    check("sw_wdata", cap_wdata, 32'hCAFEF00D);
    check("sw_addr", cap_addr, 32'h8);
    tick();

    // Misaligned word: no bus, no stall, load_data cleared
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h102;
    #1;
    check("mis_lw_flag", {31'd0, misaligned}, 32'd1);
    check("mis_lw_stall", {31'd0, stall}, 32'd0);
    tick();
    mem_read = 1'b0;
    check("mis_lw_req", {31'd0, bus_req}, 32'd0);
    check("mis_lw_data", load_data, 32'd0);
    mem_read = 1'b1; funct3 = 3'b001; addr = 32'h11;
    #1;
    check("mis_lh_flag", {31'd0, misaligned}, 32'd1);
    funct3 = 3'b001; addr = 32'h12;
    #1;
    check("ok_lh_flag", {31'd0, misaligned}, 32'd0);
    check("ok_lh_stall", {31'd0, stall}, 32'd1);
    mem_read = 1'b0;
    tick();

    // Illegal funct3
    mem_read = 1'b1; funct3 = 3'b011; addr = 32'h0;
    #1;
    check("ill_stall", {31'd0, stall}, 32'd0);
    tick();
    mem_read = 1'b0;
    check("ill_fault", {31'd0, access_fault}, 32'd1);
    check("ill_req", {31'd0, bus_req}, 32'd0);
    tick();
    check("ill_fault_clear", {31'd0, access_fault}, 32'd0);
    mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b100;
    #1;
    check("ill_both_stall", {31'd0, stall}, 32'd0);
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    check("ill_both_fault", {31'd0, access_fault}, 32'd1);
    tick();

    // Load something nonzero, then timeout must zero it
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h12345678, 0);
    tick();
    mem_read = 1'b1; funct3 = 3'b001; addr = 32'h10;
    tick();
    mem_read = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_req) break;
      req_cycles++;
      tick();
    end
    check("to_req_cycles", req_cycles, 32'd16);
    check("to_fault", {31'd0, access_fault}, 32'd1);
    check("to_data", load_data, 32'd0);
    check("to_stall", {31'd0, stall}, 32'd0);
    tick();
    check("to_fault_clear", {31'd0, access_fault}, 32'd0);

    // Bus error wins over simultaneous ack
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 0);
    tick();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h20;
    tick();
    mem_read = 1'b0;
    req_cycles = 1;
    tick(); req_cycles += bus_req ? 1 : 0;
    bus_err = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h55;
    tick(); req_cycles += bus_req ? 1 : 0;
    bus_err = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    check("err_req_cycles", req_cycles, 32'd2);
    check("err_fault", {31'd0, access_fault}, 32'd1);
    check("err_data", load_data, 32'd0);
    tick();

    // Asynchronous reset in BUSY
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    tick();
    mem_read = 1'b0;
    check("rstm_busy_req", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_req", {31'd0, bus_req}, 32'd0);
    check("rstm_stall", {31'd0, stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    check("rstm_ack_req", {31'd0, bus_req}, 32'd0);
    check("rstm_ack_data", load_data, 32'd0);
    check("rstm_ack_stall", {31'd0, stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
